// File: rtl/exec_pipe_reg_if.sv
// exec_pipe_reg_if: decode-to-execute bundle and hazard-control bus.
//   master : decode stage / hazard unit side. Drives the *_d bundle and
//            stall_e/bubble_e, and receives the *_e outputs and debug state.
//   slave  : the pipeline register itself.
// Signals:
//   stall_e, bubble_e              hazard controls
//   icode_d..d_stat                decode bundle (into the register)
//   icode_e..e_stat, valid_e       execute bundle (registered)
//   stall_cnt, bubble_cnt, ctl_err debug counters and sticky flag
interface exec_pipe_reg_if #(
    parameter int W      = 64,
    parameter int STAT_W = 3,
    parameter int CNT_W  = 16
);
    logic              stall_e;
    logic              bubble_e;
    logic [3:0]        icode_d, ifun_d, regA_d, regB_d;
    logic [W-1:0]      valA_d, valB_d, valC_d, valP_d;
    logic [STAT_W-1:0] d_stat;

    logic [3:0]        icode_e, ifun_e, regA_e, regB_e;
    logic [W-1:0]      valA_e, valB_e, valC_e, valP_e;
    logic [STAT_W-1:0] e_stat;
    logic              valid_e;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
    logic              ctl_err;

    modport master (
        output stall_e, bubble_e,
        output icode_d, ifun_d, regA_d, regB_d,
        output valA_d, valB_d, valC_d, valP_d, d_stat,
        input  icode_e, ifun_e, regA_e, regB_e,
        input  valA_e, valB_e, valC_e, valP_e, e_stat, valid_e,
        input  stall_cnt, bubble_cnt, ctl_err
    );

    modport slave (
        input  stall_e, bubble_e,
        input  icode_d, ifun_d, regA_d, regB_d,
        input  valA_d, valB_d, valC_d, valP_d, d_stat,
        output icode_e, ifun_e, regA_e, regB_e,
        output valA_e, valB_e, valC_e, valP_e, e_stat, valid_e,
        output stall_cnt, bubble_cnt, ctl_err
    );
endinterface

// File: rtl/exec_pipe_reg.sv
// exec_pipe_reg: Y86-64 decode-to-execute pipeline register.
// Latches the decode bundle each cycle, with hazard-unit stall (hold) and
// bubble (inject NOP) controls. Stall outranks bubble; seeing both at once
// sets the sticky ctl_err flag. Saturating counters record stall and bubble
// cycles. Reset is asynchronous and loads a bubble. Every output is a flop.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   exec_pipe_reg_if slave (decode bundle in, execute bundle out)
module exec_pipe_reg #(
    parameter int                W         = 64,
    parameter int                STAT_W    = 3,
    parameter int                CNT_W     = 16,
    parameter logic [3:0]        NOP_ICODE = 4'h1,
    parameter logic [3:0]        RNONE     = 4'hF,
    parameter logic [STAT_W-1:0] BUB_STAT  = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    exec_pipe_reg_if.slave bus
);
    typedef struct packed {
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [3:0]        regA;
        logic [3:0]        regB;
        logic [W-1:0]      valA;
        logic [W-1:0]      valB;
        logic [W-1:0]      valC;
        logic [W-1:0]      valP;
        logic [STAT_W-1:0] stat;
    } bundle_t;

    localparam bundle_t BUBBLE = '{
        icode: NOP_ICODE, ifun: 4'h0, regA: RNONE, regB: RNONE,
        valA: '0, valB: '0, valC: '0, valP: '0, stat: BUB_STAT
    };

    bundle_t          q;
    bundle_t          dIn;
    logic             validQ;
    logic [CNT_W-1:0] stallCnt, bubbleCnt;
    logic             ctlErr;

    assign dIn = '{
        icode: bus.icode_d, ifun: bus.ifun_d, regA: bus.regA_d, regB: bus.regB_d,
        valA: bus.valA_d, valB: bus.valB_d, valC: bus.valC_d, valP: bus.valP_d,
        stat: bus.d_stat
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q         <= BUBBLE;
            validQ    <= 1'b0;
            stallCnt  <= '0;
            bubbleCnt <= '0;
            ctlErr    <= 1'b0;
        end else if (bus.stall_e) begin
            // Hold payload and valid; a simultaneous bubble request is ignored
            // but flagged, since the hazard unit should never issue both.
            if (stallCnt != '1) stallCnt <= stallCnt + 1'b1;
            if (bus.bubble_e)   ctlErr   <= 1'b1;
        end else if (bus.bubble_e) begin
            q      <= BUBBLE;
            validQ <= 1'b0;
            if (bubbleCnt != '1) bubbleCnt <= bubbleCnt + 1'b1;
        end else begin
            q      <= dIn;
            validQ <= 1'b1;
        end
    end

    assign bus.icode_e    = q.icode;
    assign bus.ifun_e     = q.ifun;
    assign bus.regA_e     = q.regA;
    assign bus.regB_e     = q.regB;
    assign bus.valA_e     = q.valA;
    assign bus.valB_e     = q.valB;
    assign bus.valC_e     = q.valC;
    assign bus.valP_e     = q.valP;
    assign bus.e_stat     = q.stat;
    assign bus.valid_e    = validQ;
    assign bus.stall_cnt  = stallCnt;
    assign bus.bubble_cnt = bubbleCnt;
    assign bus.ctl_err    = ctlErr;
endmodule

// File: tb/tb_exec_pipe_reg.sv
module tb_exec_pipe_reg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exec_pipe_reg_if #(.W(64), .STAT_W(3), .CNT_W(16)) b ();
    exec_pipe_reg_if #(.W(64), .STAT_W(3), .CNT_W(2))  s ();

    // Second instance sees the same stimulus; only its counter width differs.
    assign s.stall_e  = b.stall_e;
    assign s.bubble_e = b.bubble_e;
    assign s.icode_d  = b.icode_d;
    assign s.ifun_d   = b.ifun_d;
    assign s.regA_d   = b.regA_d;
    assign s.regB_d   = b.regB_d;
    assign s.valA_d   = b.valA_d;
    assign s.valB_d   = b.valB_d;
    assign s.valC_d   = b.valC_d;
    assign s.valP_d   = b.valP_d;
    assign s.d_stat   = b.d_stat;

    exec_pipe_reg #(.CNT_W(16)) dut    (.clk(clk), .rst_n(rst_n), .bus(b));
    exec_pipe_reg #(.CNT_W(2))  dutSat (.clk(clk), .rst_n(rst_n), .bus(s));

    int total = 0;
    int bad   = 0;
    bit chkOn = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [3:0]  icode, ifun, regA, regB;
        logic [63:0] valA, valB, valC, valP;
        logic [2:0]  stat;
        logic        valid;
    } bun_t;

    bun_t        m;
    int unsigned mStall, mBub, mStallS, mBubS;
    bit          mErr;

    function automatic bun_t bubbleVal();
        bun_t r;
        r.icode = 4'h1; r.ifun = 4'h0; r.regA = 4'hF; r.regB = 4'hF;
        r.valA = 0; r.valB = 0; r.valC = 0; r.valP = 0;
        r.stat = 3'd0; r.valid = 1'b0;
        return r;
    endfunction

    function automatic int unsigned satInc(input int unsigned v, input int unsigned maxV);
        return (v < maxV) ? v + 1 : v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m = bubbleVal();
            mStall = 0; mBub = 0; mStallS = 0; mBubS = 0; mErr = 1'b0;
        end else if (b.stall_e) begin
            mStall  = satInc(mStall, 65535);
            mStallS = satInc(mStallS, 3);
            if (b.bubble_e) mErr = 1'b1;
        end else if (b.bubble_e) begin
            m = bubbleVal();
            mBub  = satInc(mBub, 65535);
            mBubS = satInc(mBubS, 3);
        end else begin
            m.icode = b.icode_d; m.ifun = b.ifun_d; m.regA = b.regA_d; m.regB = b.regB_d;
            m.valA = b.valA_d; m.valB = b.valB_d; m.valC = b.valC_d; m.valP = b.valP_d;
            m.stat = b.d_stat; m.valid = 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chkOn) begin
            chk("icode", b.icode_e, m.icode);
            chk("ifun",  b.ifun_e,  m.ifun);
            chk("regA",  b.regA_e,  m.regA);
            chk("regB",  b.regB_e,  m.regB);
            chk("valA",  b.valA_e,  m.valA);
            chk("valB",  b.valB_e,  m.valB);
            chk("valC",  b.valC_e,  m.valC);
            chk("valP",  b.valP_e,  m.valP);
            chk("stat",  b.e_stat,  m.stat);
            chk("valid", b.valid_e, m.valid);
            chk("stallCnt",  b.stall_cnt,  mStall);
            chk("bubbleCnt", b.bubble_cnt, mBub);
            chk("ctlErr",    b.ctl_err,    mErr);
            chk("s_icode",     s.icode_e,    m.icode);
            chk("s_valA",      s.valA_e,     m.valA);
            chk("s_valid",     s.valid_e,    m.valid);
            chk("s_stallCnt",  s.stall_cnt,  mStallS);
            chk("s_bubbleCnt", s.bubble_cnt, mBubS);
            chk("s_ctlErr",    s.ctl_err,    mErr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic setRand(input bit st, input bit bu);
        b.stall_e  = st;
        b.bubble_e = bu;
        b.icode_d  = 4'($urandom);
        b.ifun_d   = 4'($urandom);
        b.regA_d   = 4'($urandom);
        b.regB_d   = 4'($urandom);
        b.valA_d   = {$urandom, $urandom};
        b.valB_d   = {$urandom, $urandom};
        b.valC_d   = {$urandom, $urandom};
        b.valP_d   = {$urandom, $urandom};
        b.d_stat   = 3'($urandom);
    endtask

    initial begin
        logic [3:0]  xIcode, yIcode;
        logic [63:0] xValA, yValC;
        int          satExp[5];
        satExp = '{1, 2, 3, 3, 3};

        setRand(0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chkOn = 1'b1;

        // Pass-through with a known bundle.
        b.icode_d = 4'h6; b.ifun_d = 4'h0; b.regA_d = 4'h2; b.regB_d = 4'h3;
        b.valA_d = 64'h10; b.valB_d = 64'h20; b.valC_d = 64'h0; b.valP_d = 64'h0;
        b.d_stat = 3'd1;
        @(posedge clk); #1;
        chk("pt_icode", b.icode_e, 4'h6);
        chk("pt_regA",  b.regA_e,  4'h2);
        chk("pt_regB",  b.regB_e,  4'h3);
        chk("pt_valA",  b.valA_e,  64'h10);
        chk("pt_valB",  b.valB_e,  64'h20);
        chk("pt_stat",  b.e_stat,  3'd1);
        chk("pt_valid", b.valid_e, 1'b1);

        // Stall: load X, then hold it for 3 cycles while inputs change.
        @(negedge clk); setRand(0, 0);
        xIcode = b.icode_d; xValA = b.valA_d;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); setRand(1, 0);
            @(posedge clk); #1;
            chk("st_icode", b.icode_e, xIcode);
            chk("st_valA",  b.valA_e,  xValA);
        end
        chk("st_cnt",   b.stall_cnt, 3);
        chk("st_valid", b.valid_e,   1'b1);

        // Bubble for one cycle, then a fresh bundle.
        @(negedge clk); setRand(0, 1); b.valA_d = 64'hDEAD;
        @(posedge clk); #1;
        chk("bu_icode", b.icode_e,    4'h1);
        chk("bu_regA",  b.regA_e,     4'hF);
        chk("bu_valA",  b.valA_e,     64'h0);
        chk("bu_valid", b.valid_e,    1'b0);
        chk("bu_cnt",   b.bubble_cnt, 1);
        @(negedge clk); setRand(0, 0);
        yIcode = b.icode_d; yValC = b.valC_d;
        @(posedge clk); #1;
        chk("ld_icode", b.icode_e, yIcode);
        chk("ld_valC",  b.valC_e,  yValC);
        chk("ld_valid", b.valid_e, 1'b1);

        // Conflict: stall wins, error is sticky.
        @(negedge clk); setRand(1, 1);
        @(posedge clk); #1;
        chk("cf_icode",  b.icode_e,    yIcode);
        chk("cf_stall",  b.stall_cnt,  4);
        chk("cf_bubble", b.bubble_cnt, 1);
        chk("cf_err",    b.ctl_err,    1'b1);
        repeat (3) begin
            @(negedge clk); setRand(0, 0);
            @(posedge clk);
        end
        #1 chk("cf_sticky", b.ctl_err, 1'b1);

        // Asynchronous reset mid-cycle with a live bundle present.
        #2 rst_n = 1'b0;
        #1;
        chk("rs_icode",  b.icode_e,    4'h1);
        chk("rs_regA",   b.regA_e,     4'hF);
        chk("rs_regB",   b.regB_e,     4'hF);
        chk("rs_valA",   b.valA_e,     64'h0);
        chk("rs_valP",   b.valP_e,     64'h0);
        chk("rs_stat",   b.e_stat,     3'd0);
        chk("rs_valid",  b.valid_e,    1'b0);
        chk("rs_stall",  b.stall_cnt,  0);
        chk("rs_bubble", b.bubble_cnt, 0);
        chk("rs_err",    b.ctl_err,    1'b0);
        @(negedge clk); rst_n = 1'b1; setRand(0, 0);

        // Saturation on the narrow-counter instance.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); setRand(1, 0);
            @(posedge clk); #1;
            chk("sat_narrow", s.stall_cnt, satExp[i]);
            chk("sat_wide",   b.stall_cnt, i + 1);
        end

        // Randomized run with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            int r1, r2;
            @(negedge clk);
            rst_n = 1'b1;
            r1 = $urandom_range(0, 99);
            r2 = $urandom_range(0, 99);
            setRand(r1 < 30, r2 < 25);
            if ($urandom_range(0, 199) == 0) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chkOn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_pipe_reg.md
# exec_pipe_reg

Parametrised decode-to-execute pipeline register for the Y86-64 pipelined core, sitting between the decode stage and the ALU/CC execute stage. It latches the full decode bundle every cycle, and adds:
- stall (hold) and bubble (inject NOP) control for the hazard unit;
- an asynchronous active-low reset that loads a bubble;
- saturating stall/bubble event counters and a sticky illegal-control flag for debug.

## Interface
Parameters:
- W, 64: data word width (valA/valB/valC/valP)
- STAT_W, 3: status field width
- CNT_W, 16: width of each event counter
- NOP_ICODE, 4'h1: icode loaded on bubble/reset
- RNONE, 4'hF: register ID loaded on bubble/reset
- BUB_STAT, 3'd0: stat loaded on bubble/reset

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_e  in  1  hold current contents
- bubble_e  in  1  load bubble instead of decode bundle
- icode_d, ifun_d  in  4 each  decode instruction code/function
- regA_d, regB_d  in  4 each  decode register IDs
- valA_d, valB_d, valC_d, valP_d  in  W each  decode operand values
- d_stat  in  STAT_W  decode status
- icode_e, ifun_e, regA_e, regB_e  out  4 each  registered copies
- valA_e, valB_e, valC_e, valP_e  out  W each  registered copies
- e_stat  out  STAT_W  registered status
- valid_e  out  1  1 = stage holds a real (non-bubble) instruction
- stall_cnt  out  CNT_W  cycles with a stall applied
- bubble_cnt  out  CNT_W  cycles with a bubble applied
- ctl_err  out  1  sticky: stall_e and bubble_e seen high together

## Operation
Per rising edge, with rst_n high, priority is top to bottom:
- stall_e=1: all payload registers and valid_e hold. stall_cnt increments. This applies even if bubble_e=1; in that case ctl_err is also set.
- bubble_e=1 (stall_e=0): load the bubble and clear valid_e. bubble_cnt increments.
  - icode_e=NOP_ICODE, ifun_e=0
  - regA_e=regB_e=RNONE
  - valA_e/valB_e/valC_e/valP_e=0
  - e_stat=BUB_STAT
- Neither asserted: load every *_d field into its *_e register. Set valid_e=1.

Counters:
- Both counters saturate at all-ones; they never wrap.
- Each counter increments at most once per cycle.
- ctl_err stays set until reset.

Reset (rst_n=0, asynchronous, wins over everything):
- Payload outputs take the bubble values.
- valid_e=0, stall_cnt=0, bubble_cnt=0, ctl_err=0.

No combinational path from any input to any output; all outputs are flops.

## Timing
- Latency: 1 cycle, decode field to *_e output.
- Stall holds the value captured on the previous edge, for as many cycles as stall_e stays high.
- Bubble is visible on the outputs after the edge where bubble_e is sampled. It lasts one cycle unless bubble_e is held.
- Reset assertion: outputs change without waiting for clk.
- Reset deassertion: synchronised externally. The first edge with rst_n high performs a normal update per the priority above.
- Reset asserted mid-stall: the held contents are lost and the stage becomes a bubble.
- Counter at all-ones plus a further event: the counter holds all-ones, and other state updates normally.

## Test plan
- Reset: drive rst_n=0 mid-cycle with nonzero outputs present.
  - Immediately: icode_e=1, regA_e=regB_e=F, vals=0, e_stat=0, valid_e=0, counters=0, ctl_err=0.
- Pass-through: icode_d=6, ifun_d=0, regA_d=2, regB_d=3, valA_d=0x10, valB_d=0x20, d_stat=1 with no control asserted.
  - Next edge: identical values on *_e, valid_e=1.
- Stall hold: load bundle X, then stall_e=1 for 3 cycles while the *_d inputs change.
  - Outputs stay X for 3 cycles; stall_cnt=3, valid_e=1.
- Bubble: bubble_e=1 for one cycle with valA_d=0xDEAD.
  - Outputs are the bubble values, valid_e=0, bubble_cnt=1.
  - Next cycle with no control: the new bundle loads.
- Conflict: stall_e=bubble_e=1 for one cycle.
  - Outputs hold and stall_cnt increments; bubble_cnt is unchanged and ctl_err=1.
  - ctl_err stays 1 after both controls deassert, until rst_n=0.
- Saturation: build with CNT_W=2 and apply 5 stall cycles.
  - stall_cnt reads 1, 2, 3, 3, 3.
